// File: rtl/ni_flit_injector_pkg.sv
// Shared definitions for the NI flit injector.
// Holds the channel dimensions, the header flit layout, the FSM state
// encoding and a helper that builds the header flit.
package ni_flit_injector_pkg;

    localparam int V    = 4;   // virtual channels
    localparam int B    = 4;   // router input buffer depth per VC
    localparam int FW   = 32;  // flit payload width
    localparam int DSTW = 8;   // destination address width
    localparam int SZW  = 6;   // packet size field width (flits)
    localparam int CW   = $clog2(B) + 1;  // credit counter width, holds 0..B

    // Header flit layout: destination in the low bits, size just above it.
    localparam int HDR_DST_LSB  = 0;
    localparam int HDR_SIZE_LSB = HDR_DST_LSB + DSTW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic logic [FW-1:0] make_header(input logic [SZW-1:0]  size,
                                                  input logic [DSTW-1:0] dst);
        logic [FW-1:0] hdr;
        hdr = '0;
        hdr[HDR_DST_LSB  +: DSTW] = dst;
        hdr[HDR_SIZE_LSB +: SZW]  = size;
        return hdr;
    endfunction

endpackage

// File: rtl/ni_flit_injector_if.sv
// Bundle of the packet-request, body-data, flit and credit signals.
//   master : the injector (drives ready, data pop and the flit channel)
//   slave  : the environment (core/traffic generator plus router)
interface ni_flit_injector_if;
    import ni_flit_injector_pkg::*;

    logic            pck_req_valid;
    logic            pck_req_ready;
    logic [V-1:0]    pck_req_vc;
    logic [DSTW-1:0] pck_req_dst;
    logic [SZW-1:0]  pck_req_size;
    logic [FW-1:0]   pck_data;
    logic            pck_data_rd;
    logic            flit_wr_o;
    logic [FW-1:0]   flit_o;
    logic            flit_hdr_o;
    logic            flit_tail_o;
    logic [V-1:0]    flit_vc_o;
    logic [V-1:0]    credit_i;

    modport master (
        input  pck_req_valid, pck_req_vc, pck_req_dst, pck_req_size, pck_data, credit_i,
        output pck_req_ready, pck_data_rd, flit_wr_o, flit_o, flit_hdr_o, flit_tail_o, flit_vc_o
    );

    modport slave (
        output pck_req_valid, pck_req_vc, pck_req_dst, pck_req_size, pck_data, credit_i,
        input  pck_req_ready, pck_data_rd, flit_wr_o, flit_o, flit_hdr_o, flit_tail_o, flit_vc_o
    );

endinterface

// File: rtl/ni_credit_counter.sv
// Credit counter for one virtual channel.
//   clk, reset    : clock, asynchronous active-low reset
//   i_inc         : credit returned by the router this cycle
//   i_dec         : a flit issued on this VC this cycle
//   o_has_credit  : counter is non-zero (registered value only)
//   o_err         : sticky flag, a credit came back while already full
module ni_credit_counter
    import ni_flit_injector_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_has_credit,
    output logic o_err
);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= CW'(B);
            r_err <= 1'b0;
        end else if (i_inc && !i_dec) begin
            // A credit with the buffer already fully free means the router
            // returned more than we sent: hold at B and flag it.
            if (r_cnt == CW'(B)) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_has_credit = (r_cnt != '0);
    assign o_err        = r_err;

endmodule

// File: rtl/ni_flit_injector.sv
// Endpoint-side flit injector.
// Accepts a packet request, then emits header/body/tail flits on one router
// input port under per-VC credit flow control.
//   clk, reset    : clock, asynchronous active-low reset
//   bus           : request, body data, flit output and credit return
//   credit_err_o  : sticky credit overflow on any VC
//   busy_o        : a packet is in progress
module ni_flit_injector
    import ni_flit_injector_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ni_flit_injector_if.master   bus,
    output logic                 credit_err_o,
    output logic                 busy_o
);

    state_e          r_state;
    logic [V-1:0]    r_vc;
    logic [DSTW-1:0] r_dst;
    logic [SZW-1:0]  r_size;
    logic [SZW-1:0]  r_remaining;
    logic            r_hdr_pending;

    logic [V-1:0]    w_has_credit;
    logic [V-1:0]    w_err;
    logic [V-1:0]    w_dec;
    logic            w_issue;
    logic [SZW-1:0]  w_req_size;

    // A zero-length request still carries a header, so treat it as one flit.
    assign w_req_size = (bus.pck_req_size == '0) ? SZW'(1) : bus.pck_req_size;

    // Issue uses only the registered counter; a credit arriving this cycle
    // becomes usable next cycle.
    assign w_issue = (r_state == ST_SEND) && |(w_has_credit & r_vc);
    assign w_dec   = w_issue ? r_vc : '0;

    assign bus.pck_req_ready = (r_state == ST_IDLE);
    assign bus.pck_data_rd   = w_issue && !r_hdr_pending;
    assign busy_o            = (r_state == ST_SEND);
    assign credit_err_o      = |w_err;

    for (genvar g = 0; g < V; g++) begin : g_cc
        ni_credit_counter u_cc (
            .clk         (clk),
            .reset       (reset),
            .i_inc       (bus.credit_i[g]),
            .i_dec       (w_dec[g]),
            .o_has_credit(w_has_credit[g]),
            .o_err       (w_err[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_vc            <= '0;
            r_dst           <= '0;
            r_size          <= '0;
            r_remaining     <= '0;
            r_hdr_pending   <= 1'b0;
            bus.flit_wr_o   <= 1'b0;
            bus.flit_o      <= '0;
            bus.flit_hdr_o  <= 1'b0;
            bus.flit_tail_o <= 1'b0;
            bus.flit_vc_o   <= '0;
        end else begin
            bus.flit_wr_o <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (bus.pck_req_valid) begin
                        r_vc          <= bus.pck_req_vc;
                        r_dst         <= bus.pck_req_dst;
                        r_size        <= w_req_size;
                        r_remaining   <= w_req_size;
                        r_hdr_pending <= 1'b1;
                        r_state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_issue) begin
                        // Flit fields hold their last values between issues.
                        bus.flit_o      <= r_hdr_pending ? make_header(r_size, r_dst) : bus.pck_data;
                        bus.flit_hdr_o  <= r_hdr_pending;
                        bus.flit_tail_o <= (r_remaining == SZW'(1));
                        bus.flit_vc_o   <= r_vc;
                        r_hdr_pending   <= 1'b0;
                        r_remaining     <= r_remaining - SZW'(1);
                        if (r_remaining == SZW'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Self-checking bench for ni_flit_injector: directed timing checks plus a
// randomized phase; all flit contents go through a scoreboard queue.
module tb_ni_flit_injector;
    import ni_flit_injector_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic credit_err_o;
    logic busy_o;

    ni_flit_injector_if bus_if();

    ni_flit_injector dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .credit_err_o(credit_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] data;
        logic          hdr;
        logic          tail;
        logic [V-1:0]  vc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            outstanding[V];
    int            flits_seen[V];
    logic [FW-1:0] data_mem[1024];
    int            rd_idx = 0;
    int            model_idx = 0;
    logic [V-1:0]  manual_credit = '0;
    logic [V-1:0]  force_credit = '0;
    bit            auto_credit = 1'b0;
    bit            data_pend;
    logic [V-1:0]  cr_v;
    int            cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Show-ahead body data source; realigns to the model after a reset.
    initial begin
        for (int i = 0; i < 1024; i++) data_mem[i] = $urandom;
        bus_if.pck_data = data_mem[0];
        forever begin
            @(negedge clk);
            data_pend = bus_if.pck_data_rd;
            @(posedge clk);
            #1;
            if (!reset) rd_idx = model_idx;
            else if (data_pend) rd_idx = (rd_idx + 1) % 1024;
            bus_if.pck_data = data_mem[rd_idx];
        end
    end

    // Router-side credit return.
    initial begin
        bus_if.credit_i = '0;
        for (int v = 0; v < V; v++) begin
            outstanding[v] = 0;
            flits_seen[v] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int v = 0; v < V; v++) begin
                cr_v[v] = 1'b0;
                if (force_credit[v]) begin
                    cr_v[v] = 1'b1;
                end else if (outstanding[v] > 0) begin
                    if (auto_credit) cr_v[v] = ($urandom_range(0, 2) == 0);
                    else cr_v[v] = manual_credit[v];
                end
                if (cr_v[v] && outstanding[v] > 0) outstanding[v]--;
            end
            bus_if.credit_i = cr_v;
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus_if.flit_wr_o) begin
                check("flit_vc_onehot", 64'($countones(bus_if.flit_vc_o)), 64'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got flit 0x%0h with nothing expected", bus_if.flit_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("flit_data", 64'(bus_if.flit_o), 64'(mon_e.data));
                    check("flit_hdr", 64'(bus_if.flit_hdr_o), 64'(mon_e.hdr));
                    check("flit_tail", 64'(bus_if.flit_tail_o), 64'(mon_e.tail));
                    check("flit_vc", 64'(bus_if.flit_vc_o), 64'(mon_e.vc));
                end
                for (int v = 0; v < V; v++) begin
                    if (bus_if.flit_vc_o[v]) begin
                        check("router_buffer_room", 64'(outstanding[v] < B), 64'd1);
                        outstanding[v]++;
                        flits_seen[v]++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request (waits for ready) and queue the expected flits.
    task automatic send_req(input logic [V-1:0] vc, input logic [DSTW-1:0] dst,
                            input logic [SZW-1:0] size);
        int   guard = 0;
        int   sz;
        exp_t e;
        while (!bus_if.pck_req_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!bus_if.pck_req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_ready_timeout: got ready=0 expected ready=1 within 500 cycles");
            return;
        end
        bus_if.pck_req_valid = 1'b1;
        bus_if.pck_req_vc    = vc;
        bus_if.pck_req_dst   = dst;
        bus_if.pck_req_size  = size;
        sz = (size == 0) ? 1 : int'(size);
        e.data = FW'(sz * (1 << DSTW) + int'(dst));
        e.hdr  = 1'b1;
        e.tail = (sz == 1);
        e.vc   = vc;
        exp_q.push_back(e);
        for (int k = 1; k < sz; k++) begin
            e.data = data_mem[model_idx];
            model_idx = (model_idx + 1) % 1024;
            e.hdr  = 1'b0;
            e.tail = (k == sz - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.pck_req_valid = 1'b0;
    endtask

    // Return every outstanding credit and let the current packet finish.
    task automatic return_credits();
        bit           done = 1'b0;
        logic [V-1:0] m;
        for (int i = 0; i < 300 && !done; i++) begin
            m = '0;
            for (int v = 0; v < V; v++) if (outstanding[v] > 0) m[v] = 1'b1;
            manual_credit = m;
            if (m == '0 && !busy_o && exp_q.size() == 0 && !bus_if.flit_wr_o) done = 1'b1;
            else @(negedge clk);
        end
        manual_credit = '0;
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus_if.pck_req_ready), 64'd1);
        check({tag, "_flit_wr"}, 64'(bus_if.flit_wr_o), 64'd0);
        check({tag, "_credit_err"}, 64'(credit_err_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_data_rd"}, 64'(bus_if.pck_data_rd), 64'd0);
    endtask

    int base;
    int n_got;
    int first_c;
    int last_c;
    bit drained;

    initial begin
        bus_if.pck_req_valid = 1'b0;
        bus_if.pck_req_vc    = '0;
        bus_if.pck_req_dst   = '0;
        bus_if.pck_req_size  = '0;

        // Reset state, then idle after release.
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        check("in_reset_flit_o", 64'(bus_if.flit_o), 64'd0);
        check("in_reset_flit_vc", 64'(bus_if.flit_vc_o), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle");

        // Basic 3-flit packet timing.
        send_req(4'b0001, 8'h15, 6'd3);
        check("t2_n1_flit_wr", 64'(bus_if.flit_wr_o), 64'd0);
        check("t2_n1_busy", 64'(busy_o), 64'd1);
        check("t2_n1_ready", 64'(bus_if.pck_req_ready), 64'd0);
        check("t2_n1_data_rd", 64'(bus_if.pck_data_rd), 64'd0);
        @(negedge clk);
        check("t2_n2_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t2_n2_header", 64'(bus_if.flit_o), 64'h315);
        check("t2_n2_data_rd", 64'(bus_if.pck_data_rd), 64'd1);
        @(negedge clk);
        check("t2_n3_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t2_n3_tail", 64'(bus_if.flit_tail_o), 64'd0);
        check("t2_n3_data_rd", 64'(bus_if.pck_data_rd), 64'd1);
        @(negedge clk);
        check("t2_n4_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t2_n4_tail", 64'(bus_if.flit_tail_o), 64'd1);
        check("t2_n4_data_rd", 64'(bus_if.pck_data_rd), 64'd0);
        check("t2_n4_busy", 64'(busy_o), 64'd0);

        // VC0 has exactly one credit left: only the header goes out.
        base = flits_seen[0];
        send_req(4'b0001, 8'h22, 6'd3);
        repeat (6) @(negedge clk);
        check("t2_one_credit_flits", 64'(flits_seen[0] - base), 64'd1);
        check("t2_one_credit_busy", 64'(busy_o), 64'd1);
        return_credits();

        // Size 1 and size 0: single header+tail flit, back to idle at once.
        send_req(4'b0010, 8'hA7, 6'd1);
        @(negedge clk);
        check("t3_s1_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t3_s1_hdr", 64'(bus_if.flit_hdr_o), 64'd1);
        check("t3_s1_tail", 64'(bus_if.flit_tail_o), 64'd1);
        check("t3_s1_busy", 64'(busy_o), 64'd0);
        send_req(4'b0100, 8'h3C, 6'd0);
        @(negedge clk);
        check("t3_s0_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t3_s0_header", 64'(bus_if.flit_o), 64'h13C);
        check("t3_s0_tail", 64'(bus_if.flit_tail_o), 64'd1);
        check("t3_s0_busy", 64'(busy_o), 64'd0);
        return_credits();

        // Credit starvation: 4 flits, stall, one credit releases the 5th.
        base = flits_seen[0];
        send_req(4'b0001, 8'h5A, 6'd6);
        repeat (8) @(negedge clk);
        check("t4_starve_flits", 64'(flits_seen[0] - base), 64'd4);
        check("t4_starve_busy", 64'(busy_o), 64'd1);
        check("t4_starve_data_rd", 64'(bus_if.pck_data_rd), 64'd0);
        manual_credit = 4'b0001;
        @(negedge clk);
        manual_credit = '0;
        check("t4_plus1_flit_wr", 64'(bus_if.flit_wr_o), 64'd0);
        @(negedge clk);
        check("t4_plus2_flit_wr", 64'(bus_if.flit_wr_o), 64'd1);
        check("t4_plus2_flits", 64'(flits_seen[0] - base), 64'd5);
        return_credits();

        // Credits returned as flits arrive: 8 flits with no bubble.
        send_req(4'b0010, 8'h81, 6'd8);
        n_got = 0;
        first_c = -1;
        last_c = -1;
        for (int i = 0; i < 40 && n_got < 8; i++) begin
            @(negedge clk);
            if (bus_if.flit_wr_o) begin
                manual_credit = 4'b0010;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                n_got++;
            end else begin
                manual_credit = '0;
            end
        end
        manual_credit = '0;
        check("t5_flit_count", 64'(n_got), 64'd8);
        check("t5_no_bubble", 64'(last_c - first_c), 64'd7);
        return_credits();

        // Overflow on an idle, full VC; sticky until reset.
        check("t6_err_before", 64'(credit_err_o), 64'd0);
        force_credit = 4'b0100;
        @(negedge clk);
        force_credit = '0;
        @(negedge clk);
        check("t6_err_set", 64'(credit_err_o), 64'd1);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", 64'(credit_err_o), 64'd1);

        // Reset in the middle of a packet.
        send_req(4'b1000, 8'h44, 6'd5);
        n_got = 0;
        for (int i = 0; i < 20 && n_got < 2; i++) begin
            @(negedge clk);
            if (bus_if.flit_wr_o) n_got++;
        end
        check("t6_pre_reset_flits", 64'(n_got), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_flit_wr", 64'(bus_if.flit_wr_o), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        check("t6_rst_err", 64'(credit_err_o), 64'd0);
        check("t6_rst_ready", 64'(bus_if.pck_req_ready), 64'd1);
        exp_q.delete();
        for (int v = 0; v < V; v++) outstanding[v] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = flits_seen[3];
        send_req(4'b1000, 8'h45, 6'd6);
        repeat (8) @(negedge clk);
        check("t6_counter_restored", 64'(flits_seen[3] - base), 64'd4);
        check("t6_post_err", 64'(credit_err_o), 64'd0);
        return_credits();

        // Randomized traffic with a randomly returning router.
        auto_credit = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_req(4'b0001 << $urandom_range(0, 3), DSTW'($urandom), SZW'($urandom_range(0, 9)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o && outstanding[0] == 0 && outstanding[1] == 0 &&
                outstanding[2] == 0 && outstanding[3] == 0) drained = 1'b1;
        end
        auto_credit = 1'b0;
        check("rand_drained", 64'(drained), 64'd1);
        check("rand_no_overflow", 64'(credit_err_o), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
